// File: rtl/mesi_pkg.sv
// Encodings and types shared by the MESI cache FSM and the snooping bus controller.
package mesi_pkg;

    // Line state encoding as carried on line_state
    localparam logic [1:0] MESI_M = 2'b00;
    localparam logic [1:0] MESI_E = 2'b01;
    localparam logic [1:0] MESI_S = 2'b11;
    localparam logic [1:0] MESI_I = 2'b10;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_SNOOP,
        BUS_FLUSH,
        BUS_RESP
    } bus_state_e;

    localparam logic XACT_RD  = 1'b0;
    localparam logic XACT_RDX = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int N_CACHE = 4
) (
    input  logic [N_CACHE-1:0]         req,
    input  logic [$clog2(N_CACHE)-1:0] rr_ptr,
    output logic [N_CACHE-1:0]         gnt,
    output logic [$clog2(N_CACHE)-1:0] winner
);
    localparam int IW = $clog2(N_CACHE);

    int            idx;
    logic [IW-1:0] sel;

    // Scan from farthest to nearest so the nearest requester overwrites last
    always_comb begin
        winner = '0;
        gnt    = '0;
        idx    = 0;
        sel    = '0;
        for (int k = N_CACHE - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_CACHE) begin
                idx = idx - N_CACHE;
            end
            sel = IW'(idx);
            if (req[sel]) begin
                winner = sel;
            end
        end
        if (|req) begin
            gnt[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/mesi_bus_ctrl.sv
// Snooping-bus controller: arbitrates cache bus requests, broadcasts snoops,
// times owner writebacks and returns the shared indication to the requester.
module mesi_bus_ctrl
    import mesi_pkg::*;
#(
    parameter int N_CACHE   = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CACHE-1:0]     pr_req,
    input  logic [N_CACHE-1:0]     pw_req,
    input  logic [2*N_CACHE-1:0]   line_state,
    output logic [N_CACHE-1:0]     br,
    output logic [N_CACHE-1:0]     bw,
    output logic [N_CACHE-1:0]     s,
    output logic [N_CACHE-1:0]     done,
    output logic [N_CACHE-1:0]     gnt,
    output logic                   wb_busy,
    output logic                   err
);
    localparam int IW = $clog2(N_CACHE);
    localparam int CW = $clog2(FLUSH_CYC + 1);

    bus_state_e         state_q, state_d;
    logic [N_CACHE-1:0] req_vec, arb_gnt, gnt_q;
    logic [IW-1:0]      arb_winner, winner_q, rr_ptr_q;
    logic               xact_q;
    logic               shared_q, shared_d, owner_m_d, violation_d, any_s, err_q;
    int                 me_cnt;
    logic [CW-1:0]      cnt_q;

    assign req_vec = pr_req | pw_req;
    assign err     = err_q;

    rr_arbiter #(.N_CACHE(N_CACHE)) u_arb (
        .req    (req_vec),
        .rr_ptr (rr_ptr_q),
        .gnt    (arb_gnt),
        .winner (arb_winner)
    );

    // Snoop results over the non-winners; gnt_q marks the requester to skip
    always_comb begin
        shared_d  = 1'b0;
        owner_m_d = 1'b0;
        any_s     = 1'b0;
        me_cnt    = 0;
        for (int j = 0; j < N_CACHE; j++) begin
            if (!gnt_q[j]) begin
                case (line_state[2*j +: 2])
                    MESI_M: begin
                        owner_m_d = 1'b1;
                        shared_d  = 1'b1;
                        me_cnt    = me_cnt + 1;
                    end
                    MESI_E: begin
                        shared_d = 1'b1;
                        me_cnt   = me_cnt + 1;
                    end
                    MESI_S: begin
                        shared_d = 1'b1;
                        any_s    = 1'b1;
                    end
                    MESI_I:  ;
                    default: ;
                endcase
            end
        end
        violation_d = (me_cnt > 1) || ((me_cnt == 1) && any_s);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE:  if (|req_vec) state_d = BUS_SNOOP;
            BUS_SNOOP: state_d = owner_m_d ? BUS_FLUSH : BUS_RESP;
            BUS_FLUSH: if (cnt_q == '0) state_d = BUS_RESP;
            BUS_RESP:  state_d = BUS_IDLE;
            default:   state_d = BUS_IDLE;
        endcase
    end

    always_comb begin
        br      = '0;
        bw      = '0;
        s       = '0;
        done    = '0;
        gnt     = '0;
        wb_busy = 1'b0;
        if (state_q != BUS_IDLE) begin
            gnt = gnt_q;
        end
        case (state_q)
            BUS_SNOOP: begin
                if (xact_q == XACT_RDX) bw = ~gnt_q;
                else                    br = ~gnt_q;
            end
            BUS_FLUSH: wb_busy = 1'b1;
            BUS_RESP: begin
                done = gnt_q;
                if (xact_q == XACT_RD && shared_q) s = gnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BUS_IDLE;
            gnt_q    <= '0;
            winner_q <= '0;
            rr_ptr_q <= '0;
            xact_q   <= XACT_RD;
            shared_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                BUS_IDLE: begin
                    if (|req_vec) begin
                        gnt_q    <= arb_gnt;
                        winner_q <= arb_winner;
                        xact_q   <= pw_req[arb_winner] ? XACT_RDX : XACT_RD;
                    end
                end
                BUS_SNOOP: begin
                    shared_q <= shared_d;
                    if (violation_d) err_q <= 1'b1;
                    if (owner_m_d)   cnt_q <= CW'(FLUSH_CYC - 1);
                end
                BUS_FLUSH: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                BUS_RESP: begin
                    rr_ptr_q <= (winner_q == IW'(N_CACHE - 1)) ? '0 : winner_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_bus_ctrl.sv
// Directed bench for mesi_bus_ctrl; done/s pulses are checked against a scoreboard queue.
module tb_mesi_bus_ctrl;
    localparam int N = 4;
    localparam int FC = 2;
    localparam logic [1:0] LM = 2'b00, LE = 2'b01, LS = 2'b11, LI = 2'b10;

    typedef struct {
        logic [3:0] done;
        logic [3:0] s;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pr_req, pw_req;
    logic [2*N-1:0] line_state;
    logic [N-1:0] br, bw, s, done, gnt;
    logic         wb_busy, err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    mesi_bus_ctrl #(.N_CACHE(N), .FLUSH_CYC(FC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pr_req     (pr_req),
        .pw_req     (pw_req),
        .line_state (line_state),
        .br         (br),
        .bw         (bw),
        .s          (s),
        .done       (done),
        .gnt        (gnt),
        .wb_busy    (wb_busy),
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every done pulse must match the oldest expected completion
    always @(negedge clk) begin
        exp_t e;
        if (done !== 4'b0000) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("[TB] FAIL unexpected_done: observed done=%b expected no done", done);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                assert (done === e.done) else begin
                    errors++;
                    $error("[TB] FAIL done_vec: observed %b expected %b", done, e.done);
                end
                checks++;
                assert (s === e.s) else begin
                    errors++;
                    $error("[TB] FAIL s_vec: observed %b expected %b", s, e.s);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("[TB] FAIL done_cycle: observed %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] pr, input logic [3:0] pw,
                                 input logic [7:0] ls);
        pr_req     = pr;
        pw_req     = pw;
        line_state = ls;
    endtask

    task automatic expectDone(input logic [3:0] d, input logic [3:0] sv, input int lat);
        exp_t e;
        e.done = d;
        e.s    = sv;
        e.cyc  = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_br"}, br, 4'b0000);
        checkOutput({tag, "_bw"}, bw, 4'b0000);
        checkOutput({tag, "_s"}, s, 4'b0000);
        checkOutput({tag, "_done"}, done, 4'b0000);
        checkOutput({tag, "_gnt"}, gnt, 4'b0000);
        checkOutput({tag, "_wb"}, {3'b000, wb_busy}, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting mesi_bus_ctrl bench");
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();
        tick();
        rst = 1'b0;
        checkIdle("reset");
        checkOutput("reset_err", {3'b000, err}, 4'b0000);

        // Cache 0 read miss, cache 2 holds S: shared read
        applyStimulus(4'b0001, 4'b0000, {LI, LS, LI, LI});
        expectDone(4'b0001, 4'b0001, 2);
        tick();
        checkOutput("rd_br", br, 4'b1110);
        checkOutput("rd_bw", bw, 4'b0000);
        checkOutput("rd_gnt", gnt, 4'b0001);
        tick();
        checkOutput("rd_gnt_resp", gnt, 4'b0001);
        applyStimulus(4'b0000, 4'b0000, {LI, LS, LI, LI});
        tick();
        checkIdle("rd_after");

        // Cache 2 write miss with cache 0 in M: writeback then done
        applyStimulus(4'b0000, 4'b0100, {LI, LI, LI, LM});
        expectDone(4'b0100, 4'b0000, 2 + FC);
        tick();
        checkOutput("rdx_bw", bw, 4'b1011);
        checkOutput("rdx_br", br, 4'b0000);
        tick();
        checkOutput("flush_wb1", {3'b000, wb_busy}, 4'b0001);
        checkOutput("flush_gnt", gnt, 4'b0100);
        tick();
        checkOutput("flush_wb2", {3'b000, wb_busy}, 4'b0001);
        tick();
        checkOutput("resp_wb", {3'b000, wb_busy}, 4'b0000);
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();
        checkIdle("rdx_after");
        checkOutput("rdx_err", {3'b000, err}, 4'b0000);

        // Cache 1 with both requests set: read-exclusive wins
        applyStimulus(4'b0010, 4'b0010, {LI, LI, LI, LE});
        expectDone(4'b0010, 4'b0000, 2);
        tick();
        checkOutput("both_bw", bw, 4'b1101);
        checkOutput("both_br", br, 4'b0000);
        tick();
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();

        // Caches 1 and 3 together from rr_ptr=2: cache 3 first, then cache 1
        applyStimulus(4'b1010, 4'b0000, {LI, LI, LI, LI});
        expectDone(4'b1000, 4'b0000, 2);
        tick();
        checkOutput("rr_first_gnt", gnt, 4'b1000);
        checkOutput("rr_first_br", br, 4'b0111);
        tick();
        applyStimulus(4'b0010, 4'b0000, {LI, LI, LI, LI});
        expectDone(4'b0010, 4'b0000, 3);
        tick();
        checkOutput("rr_gap_gnt", gnt, 4'b0000);
        tick();
        checkOutput("rr_second_gnt", gnt, 4'b0010);
        tick();
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();

        // All four request continuously: full rotation 2,3,0,1 across the wrap
        applyStimulus(4'b1111, 4'b0000, {LI, LI, LI, LI});
        expectDone(4'b0100, 4'b0000, 2);
        expectDone(4'b1000, 4'b0000, 5);
        expectDone(4'b0001, 4'b0000, 8);
        expectDone(4'b0010, 4'b0000, 11);
        begin
            logic [3:0] order [4];
            order[0] = 4'b0100;
            order[1] = 4'b1000;
            order[2] = 4'b0001;
            order[3] = 4'b0010;
            for (int k = 0; k < 4; k++) begin
                tick();
                checkOutput("rot_gnt", gnt, order[k]);
                tick();
                if (k == 3) applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
                tick();
            end
        end

        // Caches 2 and 3 both M: coherence violation, sticky
        applyStimulus(4'b0001, 4'b0000, {LM, LM, LI, LI});
        expectDone(4'b0001, 4'b0001, 2 + FC);
        tick();
        tick();
        checkOutput("viol_err", {3'b000, err}, 4'b0001);
        tick();
        tick();
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();
        applyStimulus(4'b0010, 4'b0000, {LI, LI, LI, LI});
        expectDone(4'b0010, 4'b0000, 2);
        tick();
        tick();
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();
        checkOutput("err_sticky", {3'b000, err}, 4'b0001);

        // Reset on the second FLUSH cycle: no done, everything cleared
        applyStimulus(4'b0000, 4'b1000, {LI, LI, LI, LM});
        tick();
        checkOutput("pre_rst_bw", bw, 4'b0111);
        tick();
        checkOutput("pre_rst_wb", {3'b000, wb_busy}, 4'b0001);
        tick();
        rst = 1'b1;
        tick();
        checkIdle("mid_rst");
        checkOutput("mid_rst_err", {3'b000, err}, 4'b0000);
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();
        tick();
        checkIdle("post_rst");

        // rr_ptr back at 0 after reset: cache 1 beats cache 3
        applyStimulus(4'b1010, 4'b0000, {LI, LI, LI, LS});
        expectDone(4'b0010, 4'b0010, 2);
        tick();
        checkOutput("rst_ptr_gnt", gnt, 4'b0010);
        tick();
        applyStimulus(4'b0000, 4'b0000, {LI, LI, LI, LI});
        tick();
        tick();

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("[TB] FAIL pending_done: observed %0d outstanding expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_bus_ctrl.md
# mesi_bus_ctrl

Snooping-bus controller for the single-line MESI model. It is the bus-side counterpart of the per-cache `mesi_fsm`: it arbitrates processor-side bus requests from N caches and broadcasts the winning transaction as `br`/`bw` snoop strobes to every other cache. It also collects those caches' line states, handles a modified-owner writeback, and returns the shared indication `s` to the requester. One instance sits between the cache array and the shared bus.

## Interface
- `N_CACHE`, default 4: number of attached caches; minimum 2.
- `FLUSH_CYC`, default 2: writeback duration in cycles when a snooped owner holds M; minimum 1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pr_req` in N_CACHE: per-cache bus read request (read miss); level, held until `done`.
- `pw_req` in N_CACHE: per-cache bus read-exclusive request (write miss/upgrade); level, held until `done`.
- `line_state` in 2*N_CACHE: current MESI state of each cache, with cache i at bits [2i+1:2i]. Encoding: M=00, E=01, S=11, I=10.
- `br` out N_CACHE: one-cycle snoop-read strobe, driven to every cache except the requester.
- `bw` out N_CACHE: one-cycle snoop-write (invalidate) strobe, driven to every cache except the requester.
- `s` out N_CACHE: shared indication to the requester; valid only while `done` is high for that cache.
- `done` out N_CACHE: one-hot, one-cycle transaction-complete pulse.
- `gnt` out N_CACHE: one-hot current bus owner; held from SNOOP through RESP.
- `wb_busy` out 1: high during a writeback.
- `err` out 1: sticky coherence violation; cleared only by `rst`.

## Operation
- FSM states: IDLE, SNOOP, FLUSH, RESP.
- **IDLE**
  - Requester set = `pr_req | pw_req`. If it is non-zero, select a winner round-robin, starting from `rr_ptr`.
  - Register the winner index and the transaction type, then move to SNOOP.
  - Type is RDX if the winner's `pw_req` is set, otherwise RD. `pw` wins when both are set.
- **SNOOP** (exactly one cycle)
  - RD: `br[j]`=1 for all j≠winner. RDX: `bw[j]`=1 for all j≠winner.
  - Sample `line_state` of all non-winners in this cycle:
    - shared = any non-winner ≠ I.
    - owner_m = any non-winner == M.
  - Next state: FLUSH if owner_m, else RESP.
- **FLUSH**
  - `wb_busy`=1 for FLUSH_CYC cycles, timed by a down-counter loaded on entry.
  - Go to RESP when the counter reaches 0.
- **RESP** (one cycle)
  - `done[winner]`=1.
  - `s[winner]`=shared for RD; `s[winner]`=0 for RDX, since all other copies are invalidated.
  - Set `rr_ptr` = (winner+1) mod N_CACHE, then return to IDLE.
- `err` sets in SNOOP if either holds:
  - more than one non-winner is M or E;
  - one non-winner is M or E while any other non-winner is S.
- Requests that drop mid-transaction do not abort it; `done` still pulses.
- A request that is still asserted in IDLE after its `done` is treated as a new transaction.

## Timing
- Reset values: all outputs 0, FSM IDLE, `rr_ptr`=0, flush counter 0, `err`=0.
- Latency without writeback: request seen in IDLE at edge t → `br`/`bw` during cycle t+1 → `done` during cycle t+2.
- Latency with writeback: `done` during cycle t+2+FLUSH_CYC.
- `gnt` rises in the cycle after IDLE sampling and falls after RESP. Minimum spacing between consecutive transactions is one IDLE cycle.
- The snoop strobes are never asserted toward the requester. `br` and `bw` are never both asserted in one cycle.
- Simultaneous requests from several caches: exactly one is granted per transaction, in round-robin order from `rr_ptr`.
- `rst` in any state, including mid-FLUSH, forces IDLE on the next edge and clears all outputs. A partially completed transaction produces no `done`.
- The `rr_ptr` wrap-around from N_CACHE-1 to 0 is exercised by full rotation.

## Structure
- Shared package `mesi_pkg`:
  - MESI state encodings M/E/S/I, shared with `mesi_fsm`;
  - bus FSM state enum;
  - transaction-type constants RD/RDX.
- Sub-module `rr_arbiter`:
  - parameterised by N_CACHE;
  - inputs: request vector, `rr_ptr`;
  - outputs: one-hot grant and winner index;
  - purely combinational.
- Top level holds the FSM, flush counter, `rr_ptr`, snoop-result registers and `err`.

## Test plan
- Reset, then cache 0 `pr_req`=1 with others in I, S, I (caches 1–3) → `br`=1110 for one cycle, then `done`=0001 with `s[0]`=1 two cycles after the request.
- Cache 2 `pw_req`=1 with cache 0 in M, FLUSH_CYC=2 → `bw`=1011, `wb_busy` high for 2 cycles, `done[2]` at t+4, `s[2]`=0.
- Caches 1 and 3 request in the same cycle with `rr_ptr`=2 → cache 3 served first, then cache 1. Repeat until `rr_ptr` wraps 3→0.
- Cache 1 asserts both `pr_req` and `pw_req` → RDX: `bw` used, `br` stays 0.
- Caches 2 and 3 both in M during a snoop → `err`=1 and stays 1 until `rst`.
- `rst` asserted on the second FLUSH cycle → next cycle IDLE, all outputs 0, no `done` pulse.
